cond_delay_checker: RTL and testbench

Clocked checker for the conditional pin-to-pin delays of the `a`/`b`/`c`/`d` → `out` AND-tree cell.
- Samples the cell's four inputs and its output, computes the expected logic value and the expected conditional delay in clock cycles, and measures the actual input-to-output delay.
- Flags each transition as pass or fail.
- Sits in the verification harness beside the delay-annotated cell. It is the checking end of the timing contract that the cell's specify block declares.

---
 rtl/cond_delay_checker_if.sv | 34 +++
 rtl/cond_delay_checker.sv | 151 +++++++++++++++
 tb/tb_cond_delay_checker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cond_delay_checker_if.sv
// Bundle between the delay-annotated AND-tree cell and its checker.
// Latency: none, wires only.
// Backpressure: none; every report and error is a single-cycle pulse.
interface cond_delay_checker_if #(
  parameter int CNT_W = 6
);
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             out_obs;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_cycles;
  logic [CNT_W-1:0] exp_cycles;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic             glitch_err;
  logic [7:0]       err_count;

  // Harness side: drives the cell inputs and the observed output
  modport master (
    output a, b, c, d, out_obs,
    input  meas_valid, meas_cycles, exp_cycles, pass, fail, timeout,
           glitch_err, err_count
  );

  // Checker side
  modport slave (
    input  a, b, c, d, out_obs,
    output meas_valid, meas_cycles, exp_cycles, pass, fail, timeout,
           glitch_err, err_count
  );
endinterface

// File: rtl/cond_delay_checker.sv
// Measures the a/b/c/d -> out delay of the AND-tree cell against its conditional rule delays.
// Latency: a report is registered on the edge that sees the output match (meas_valid one cycle later).
// Backpressure: none; reports and glitch errors are fire-and-forget pulses.
module cond_delay_checker #(
  parameter int TOL     = 0,
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 6   // must match the interface CNT_W and hold TIMEOUT
) (
  input logic                 clock,
  input logic                 reset,
  cond_delay_checker_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_d;
  logic [3:0]       in_now, in_q, chg;
  logic             change;
  logic             exp_out;
  // exp_q is the output value the checker has accepted as settled. It only
  // moves when a transition is confirmed, so an input change that is undone
  // before the output responds cancels out instead of starting a new check.
  // A timed-out transition is not accepted, so glitch detection keeps
  // tracking what the output actually did.
  logic             exp_q, exp_q_d;
  logic             target, target_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] exp_lat, exp_lat_d;
  logic [CNT_W-1:0] rule_dly;
  logic             start;
  logic             rep, rep_to, rep_pass, glitch;
  logic [CNT_W-1:0] rep_meas, rep_exp;
  logic [CNT_W:0]   diff;

  assign in_now  = {bus.a, bus.b, bus.c, bus.d};
  assign chg     = in_now ^ in_q;
  assign change  = |chg;
  assign exp_out = &in_now;

  // Rule delay: largest delay among the inputs that changed, conditions taken on new values
  always_comb begin
    rule_dly = '0;
    if (chg[3])
      rule_dly = bus.a ? CNT_W'(9) : CNT_W'(10);
    if (chg[2] && ((bus.b && bus.c) ? CNT_W'(9) : CNT_W'(13)) > rule_dly)
      rule_dly = (bus.b && bus.c) ? CNT_W'(9) : CNT_W'(13);
    if ((chg[1] || chg[0]) &&
        (({bus.c, bus.d} == 2'b01) ? CNT_W'(11) : CNT_W'(13)) > rule_dly)
      rule_dly = ({bus.c, bus.d} == 2'b01) ? CNT_W'(11) : CNT_W'(13);
  end

  // Next-state and report decode; match beats timeout beats preemption in WAIT
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    target_d  = target;
    exp_lat_d = exp_lat;
    exp_q_d   = exp_q;
    start     = 1'b0;
    rep       = 1'b0;
    rep_to    = 1'b0;
    rep_meas  = '0;
    glitch    = 1'b0;

    case (state)
      IDLE: start = 1'b1;
      WAIT: begin
        if (bus.out_obs == target) begin
          rep      = 1'b1;
          rep_meas = cnt;
          exp_q_d  = target;
          state_d  = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          rep      = 1'b1;
          rep_to   = 1'b1;
          rep_meas = CNT_W'(TIMEOUT);
          state_d  = IDLE;
        end else if (change) begin
          start = 1'b1;   // preempted: current measurement dropped silently
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      if (change && (exp_out != exp_q)) begin
        exp_lat_d = rule_dly;
        target_d  = exp_out;
        if (bus.out_obs == exp_out) begin
          rep      = 1'b1;
          rep_meas = '0;
          exp_q_d  = exp_out;
          state_d  = IDLE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = WAIT;
        end
      end else if (change) begin
        state_d = IDLE;
      end else if ((state == IDLE) && (bus.out_obs != exp_q)) begin
        glitch = 1'b1;
      end
    end

    rep_exp  = exp_lat_d;
    diff     = (rep_meas >= rep_exp) ? ({1'b0, rep_meas} - {1'b0, rep_exp})
                                     : ({1'b0, rep_exp} - {1'b0, rep_meas});
    rep_pass = !rep_to && (int'(diff) <= TOL);
  end

  // Checker state and registered report outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      in_q            <= '0;
      exp_q           <= 1'b0;
      target          <= 1'b0;
      cnt             <= '0;
      exp_lat         <= '0;
      bus.meas_valid  <= 1'b0;
      bus.meas_cycles <= '0;
      bus.exp_cycles  <= '0;
      bus.pass        <= 1'b0;
      bus.fail        <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.glitch_err  <= 1'b0;
      bus.err_count   <= '0;
    end else begin
      state          <= state_d;
      in_q           <= in_now;
      exp_q          <= exp_q_d;
      target         <= target_d;
      cnt            <= cnt_d;
      exp_lat        <= exp_lat_d;
      bus.meas_valid <= rep;
      bus.glitch_err <= glitch;
      bus.pass       <= rep && rep_pass;
      bus.fail       <= rep && !rep_pass;
      if (rep) begin
        bus.meas_cycles <= rep_meas;
        bus.exp_cycles  <= rep_exp;
        bus.timeout     <= rep_to;
      end
      if (((rep && !rep_pass) || glitch) && (bus.err_count != 8'hFF))
        bus.err_count <= bus.err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cond_delay_checker.sv
// Scoreboard bench: two checkers (TOL=0 and TOL=2) watch the same cell activity.
// Latency: expectations are queued at stimulus time and popped on each output pulse.
// Backpressure: none.
module tb_cond_delay_checker;

  logic clock;
  logic reset;

  cond_delay_checker_if #(.CNT_W(6)) bus ();
  cond_delay_checker_if #(.CNT_W(6)) bus2 ();

  assign bus2.a       = bus.a;
  assign bus2.b       = bus.b;
  assign bus2.c       = bus.c;
  assign bus2.d       = bus.d;
  assign bus2.out_obs = bus.out_obs;

  cond_delay_checker #(.TOL(0), .TIMEOUT(31), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  cond_delay_checker #(.TOL(2), .TIMEOUT(31), .CNT_W(6)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    bit is_glitch;
    int meas;
    int expc;
    bit pas;
    bit to;
    int err;
  } ev_t;

  ev_t q0[$];
  ev_t q2[$];
  ev_t e0, e2;
  int  n_checks = 0;
  int  n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_ev(input string tag, input ev_t e, input logic gl,
                        input logic [5:0] mc, input logic [5:0] ec,
                        input logic ps, input logic fl, input logic to,
                        input logic [7:0] errc);
    check({tag, "_glitch"}, {31'd0, gl}, {31'd0, e.is_glitch});
    if (!e.is_glitch) begin
      check({tag, "_meas"},    {26'd0, mc}, e.meas);
      check({tag, "_exp"},     {26'd0, ec}, e.expc);
      check({tag, "_pass"},    {31'd0, ps}, {31'd0, e.pas});
      check({tag, "_fail"},    {31'd0, fl}, {31'd0, !e.pas});
      check({tag, "_timeout"}, {31'd0, to}, {31'd0, e.to});
    end
    check({tag, "_err_count"}, {24'd0, errc}, e.err);
  endtask

  task automatic push(input bit g, input int meas, input int expc, input bit to,
                      input bit p0, input int err0, input bit p2, input int err2);
    q0.push_back('{is_glitch: g, meas: meas, expc: expc, pas: p0, to: to, err: err0});
    q2.push_back('{is_glitch: g, meas: meas, expc: expc, pas: p2, to: to, err: err2});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_in(input logic [3:0] v);
    {bus.a, bus.b, bus.c, bus.d} = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mv"},    {31'd0, bus.meas_valid},  0);
    check({tag, "_mc"},    {26'd0, bus.meas_cycles}, 0);
    check({tag, "_ec"},    {26'd0, bus.exp_cycles},  0);
    check({tag, "_to"},    {31'd0, bus.timeout},     0);
    check({tag, "_pf"},    {30'd0, bus.pass, bus.fail}, 0);
    check({tag, "_gl"},    {31'd0, bus.glitch_err},  0);
    check({tag, "_err"},   {24'd0, bus.err_count},   0);
    check({tag, "_mc2"},   {26'd0, bus2.meas_cycles}, 0);
    check({tag, "_err2"},  {24'd0, bus2.err_count},  0);
  endtask

  // Monitor for the TOL=0 checker
  always @(negedge clock) begin
    if (bus.meas_valid || bus.glitch_err) begin
      check("tol0_event_expected", {31'd0, q0.size() != 0}, 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk_ev("tol0", e0, bus.glitch_err, bus.meas_cycles, bus.exp_cycles,
               bus.pass, bus.fail, bus.timeout, bus.err_count);
      end
    end
  end

  // Monitor for the TOL=2 checker
  always @(negedge clock) begin
    if (bus2.meas_valid || bus2.glitch_err) begin
      check("tol2_event_expected", {31'd0, q2.size() != 0}, 1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk_ev("tol2", e2, bus2.glitch_err, bus2.meas_cycles, bus2.exp_cycles,
               bus2.pass, bus2.fail, bus2.timeout, bus2.err_count);
      end
    end
  end

  initial begin
    reset = 1'b0;
    set_in(4'b0111);
    bus.out_obs = 1'b0;
    #1 reset = 1'b1;
    step(2);
    check_zero("reset");
    reset = 1'b0;
    step(2);   // first edge sees 0111 vs 0000: expected value unchanged, no report

    // 0111 -> 1111, output rises after 9 cycles
    push(0, 9, 9, 0, 1, 0, 1, 0);
    set_in(4'b1111); step(9); bus.out_obs = 1'b1; step(3);

    // 1111 -> 0111, output falls after 10 cycles
    push(0, 10, 10, 0, 1, 0, 1, 0);
    set_in(4'b0111); step(10); bus.out_obs = 1'b0; step(3);

    // back to 1111 for the next case
    push(0, 9, 9, 0, 1, 0, 1, 0);
    set_in(4'b1111); step(9); bus.out_obs = 1'b1; step(3);

    // 1111 -> 1110 ({c,d}=10, rule 13), output falls after 11: fails TOL 0, passes TOL 2
    push(0, 11, 13, 0, 0, 1, 1, 0);
    set_in(4'b1110); step(11); bus.out_obs = 1'b0; step(3);

    // 0111 -> 1111 with the output stuck low: timeout at 31
    set_in(4'b0111); step(2);
    push(0, 31, 9, 1, 0, 2, 0, 1);
    set_in(4'b1111); step(40);

    // Preemption: 0111 -> 1111, back to 0111 four cycles later, no report
    set_in(4'b0111); step(2);
    set_in(4'b1111); step(4);
    set_in(4'b0111); step(10);

    // Glitch: static 0000, output high for one cycle
    set_in(4'b0000); step(2);
    push(1, 0, 0, 0, 0, 3, 0, 2);
    bus.out_obs = 1'b1; step(1); bus.out_obs = 1'b0; step(3);

    // Reset five cycles into a wait (0000 -> 1111)
    set_in(4'b1111); step(5);
    reset = 1'b1;
    #1 check_zero("midwait_reset");
    bus.out_obs = 1'b1;
    step(2);
    // release with 1111 and output high: immediate report, rule max(9,9,13)=13
    push(0, 0, 13, 0, 0, 1, 0, 1);
    reset = 1'b0;
    step(5);

    check("tol0_pending_at_end", q0.size(), 0);
    check("tol2_pending_at_end", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
